block_out: RTL and testbench
============================

BLOCK_OUT -- requirements
Module: block_out

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the spike/value word width.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of buffered output events (power of two, >=2).
REQ-003 Parameter CNT_W, default 8, SHALL set the width of the drop counter.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 node_out  input  WIDTH  SHALL carry the node's output value, sampled every rising edge.
REQ-007 fab_data  output  WIDTH  SHALL carry the oldest buffered event toward the IO fabric.
REQ-008 fab_valid  output  1  SHALL indicate that fab_data holds a valid event.
REQ-009 fab_ready  input  1  SHALL indicate that the fabric accepts fab_data this cycle.
REQ-010 drop_cnt  output  CNT_W  SHALL count events lost to a full buffer.
REQ-011 full  output  1  SHALL be high when DEPTH events are buffered.
REQ-012 empty  output  1  SHALL be high when no events are buffered.

Function
REQ-013 A non-zero node_out at a rising edge SHALL be a push request; a zero node_out SHALL never be buffered.
REQ-014 A pop SHALL occur at a rising edge where fab_valid and fab_ready are both high.
REQ-015 fab_valid SHALL equal not-empty; fab_data SHALL equal the head entry and be 0 when empty.
REQ-016 While fab_valid is high and fab_ready is low, fab_data SHALL stay unchanged.
REQ-017 Latency: push into an empty buffer at edge N SHALL give fab_valid high and fab_data = pushed value from edge N until the pop edge.
REQ-018 Events SHALL leave in push order (FIFO), one per pop.
REQ-019 Occupancy SHALL range 0..DEPTH; read/write pointers SHALL wrap modulo DEPTH.
REQ-020 Push and pop at the same edge with 0 < occupancy <= DEPTH SHALL both be performed, leaving occupancy unchanged; a push to a full buffer with a simultaneous pop SHALL be accepted, not dropped.
REQ-021 Push and pop at the same edge with empty buffer: no pop occurs (fab_valid low); the push SHALL be accepted.
REQ-022 A push to a full buffer without a simultaneous pop SHALL be discarded and drop_cnt SHALL increment by 1.
REQ-023 drop_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 A pop from an empty buffer SHALL be impossible (fab_valid low); pointers SHALL not move.
REQ-025 full and empty SHALL be derived from registered occupancy, never both high.

Reset
REQ-026 rst_n low SHALL immediately clear pointers and occupancy, forcing fab_valid=0, fab_data=0, empty=1, full=0, drop_cnt=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered events; no event pushed before reset SHALL appear afterward.
REQ-028 The first push request SHALL be honoured at the first rising edge after rst_n deasserts.
REQ-029 Buffer storage contents need not be reset, but fab_data SHALL read 0 while empty.

Structure
REQ-030 WIDTH, DEPTH and CNT_W defaults SHALL live in the shared package block_pkg, alongside the existing fabric word width.
REQ-031 Storage, pointers and occupancy SHALL be in one sub-module, evt_fifo; block_out SHALL hold push filtering, handshake and drop counter.
REQ-032 block_out SHALL connect directly to a node's out port with no further glue.

Verification
REQ-033 Reset, node_out=4'h3 one cycle, fab_ready=1 -> fab_valid high one cycle, fab_data=4'h3, then empty=1.
REQ-034 node_out=0 for 10 cycles -> fab_valid stays 0, drop_cnt=0.
REQ-035 fab_ready=0, push 1,2,3,4,5,6 -> full=1 after 4th, drop_cnt=2, then fab_ready=1 drains 1,2,3,4 in order.
REQ-036 Full buffer, fab_ready=1, push 4'h9 same edge as pop -> occupancy stays 4, drop_cnt unchanged, 4'h9 last out.
REQ-037 fab_ready=0 with 300 pushes on full buffer -> drop_cnt=255 (saturated).
REQ-038 Three events buffered, rst_n pulsed low mid-cycle -> fab_valid=0 immediately, no old event emitted after release.

Source files
------------

// File: rtl/block_pkg.sv
// Shared parameters for the node output path toward the IO fabric.
package block_pkg;

    localparam int FAB_W     = 4;
    localparam int WIDTH_DEF = FAB_W;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/block_out_evt_fifo.sv
// Event FIFO: storage, wrapping pointers and occupancy.
// Head reads as zero while empty.
module evt_fifo
    import block_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);

    // A pop frees a slot in the same edge, so a full FIFO still accepts.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign data_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/block_out.sv
// Node output stage: filters zero words, buffers events for the
// fabric handshake and counts events lost to a full buffer.
module block_out
    import block_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] node_out,
    output logic [WIDTH-1:0] fab_data,
    output logic             fab_valid,
    input  logic             fab_ready,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             full,
    output logic             empty
);

    logic             push_req;
    logic             pop;
    logic             drop;
    logic [CNT_W-1:0] drop_q, drop_d;

    assign push_req  = |node_out;
    assign fab_valid = !empty;
    assign pop       = fab_valid && fab_ready;
    assign drop      = push_req && full && !pop;

    evt_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_req),
        .pop_i   (pop),
        .data_i  (node_out),
        .data_o  (fab_data),
        .full_o  (full),
        .empty_o (empty)
    );

    // Saturating: stays at all-ones once reached.
    always_comb begin
        drop_d = drop_q;
        if (drop && (drop_q != '1)) drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_q <= '0;
        else        drop_q <= drop_d;
    end

    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_block_out.sv
// Randomised scoreboard bench for block_out against a queue model.
module tb_block_out;

    localparam int DEPTH = 4;
    localparam int SAT   = 255;

    logic       clk;
    logic       rst_n;
    logic [3:0] node_out;
    logic [3:0] fab_data;
    logic       fab_valid;
    logic       fab_ready;
    logic [7:0] drop_cnt;
    logic       full;
    logic       empty;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 0;

    int mq[$];
    int exp_q[$];
    int mdrop = 0;

    block_out dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .node_out  (node_out),
        .fab_data  (fab_data),
        .fab_valid (fab_valid),
        .fab_ready (fab_ready),
        .drop_cnt  (drop_cnt),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Model update happens just after the edge consuming the inputs.
    task automatic drive(input int v, input bit r);
        bit do_pop;
        node_out  = 4'(v);
        fab_ready = r;
        do_pop    = r && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (do_pop) void'(mq.pop_front());
        if (v != 0) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(v);
                exp_q.push_back(v);
            end else if (mdrop < SAT) begin
                mdrop++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid", int'(fab_valid), int'(mq.size() != 0));
            chk("empty", int'(empty), int'(mq.size() == 0));
            chk("full", int'(full), int'(mq.size() == DEPTH));
            chk("drop_cnt", int'(drop_cnt), mdrop);
            if (!fab_valid) chk("data_idle", int'(fab_data), 0);
            if (fab_valid && fab_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", int'(fab_data), -1);
                end else begin
                    chk("data", int'(fab_data), exp_q.pop_front());
                end
            end
        end
    end

    task automatic pulse_reset();
        #2;
        rst_n = 0;
        #1;
        chk("rst_valid", int'(fab_valid), 0);
        chk("rst_data", int'(fab_data), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        mq.delete();
        exp_q.delete();
        mdrop = 0;
        node_out  = 0;
        fab_ready = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        rst_n     = 1;
        node_out  = 0;
        fab_ready = 0;
        @(posedge clk);
        #1;
        pulse_reset();
        mon_en = 1;

        drive(3, 1);
        for (int i = 0; i < 3; i++) drive(0, 1);

        for (int i = 0; i < 10; i++) drive(0, 1'($urandom));

        for (int i = 1; i <= 6; i++) drive(i, 0);
        chk("full_after_6", int'(full), 1);
        chk("drop_after_6", int'(drop_cnt), 2);
        for (int i = 0; i < DEPTH + 2; i++) drive(0, 1);

        for (int i = 0; i < DEPTH; i++) drive(i + 10, 0);
        drive(9, 1);
        chk("full_after_swap", int'(full), 1);
        for (int i = 0; i < DEPTH + 2; i++) drive(0, 1);

        for (int i = 0; i < 300; i++) drive(int'($urandom_range(1, 15)), 0);
        chk("drop_saturated", int'(drop_cnt), SAT);
        for (int i = 0; i < DEPTH + 2; i++) drive(0, 1);

        for (int i = 0; i < 2000; i++) begin
            int v;
            v = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
            drive(v, ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < DEPTH + 2; i++) drive(0, 1);

        for (int i = 0; i < 3; i++) drive(int'($urandom_range(1, 15)), 0);
        chk("pre_reset_valid", int'(fab_valid), 1);
        pulse_reset();
        drive(5, 1);
        for (int i = 0; i < DEPTH + 2; i++) drive(0, 1);

        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
